// File: rtl/controle_manobra_re_pkg.sv
// Shared definitions for the reverse-manoeuvre controller.
//   estado_t          : controller states
//   motor_t / codes   : per-motor drive code (PARADO, FRENTE, TRAS)
//   motores_t         : left/right motor pair
//   motores_do_estado : motor driver, maps state + turn flag to motor codes
//   carga             : counter load value for a state lasting t cycles
package controle_manobra_re_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ANDANDO = 3'd0,
    PARADA  = 3'd1,
    RE      = 3'd2,
    GIRO    = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  typedef logic [1:0] motor_t;

  localparam motor_t PARADO = 2'b00;
  localparam motor_t FRENTE = 2'b01;
  localparam motor_t TRAS   = 2'b10;

  typedef struct packed {
    motor_t esquerdo;
    motor_t direito;
  } motores_t;

  // Motor driver: the code 11 is never produced.
  function automatic motores_t motores_do_estado(estado_t estado, logic gira_esq);
    motores_t m;
    m.esquerdo = PARADO;
    m.direito  = PARADO;
    case (estado)
      ANDANDO: begin
        m.esquerdo = FRENTE;
        m.direito  = FRENTE;
      end
      RE: begin
        m.esquerdo = TRAS;
        m.direito  = TRAS;
      end
      GIRO: begin
        m.esquerdo = gira_esq ? TRAS   : FRENTE;
        m.direito  = gira_esq ? FRENTE : TRAS;
      end
      default: begin
        m.esquerdo = PARADO;
        m.direito  = PARADO;
      end
    endcase
    return m;
  endfunction

  // The counter counts down to zero inclusive, so a state lasting t cycles loads t-1.
  function automatic logic [CNT_W-1:0] carga(int unsigned t);
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/controle_manobra_re_contador.sv
// contador_manobra: loadable 8-bit down-counter for state durations.
//   Clk, Reset : clock and synchronous active-high reset (clears to 0)
//   load, valor: load valor on this edge (has priority over en)
//   en         : decrement by one; holds at zero, never wraps
//   zero       : count is zero
module contador_manobra
  import controle_manobra_re_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] valor,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = valor;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_manobra_re.sv
// controle_manobra_re: reverse-and-turn manoeuvre controller for a two-motor robot.
//   Clk, Reset                       : clock, synchronous active-high reset
//   Pedido_Re                        : reverse request (accepted only while driving forward)
//   Sensor_Direito, Sensor_Esquerdo  : side obstacles, pick the turn direction
//   Sensor_Trazeiro                  : rear obstacle, cuts reversing short
//   Saida_Erro                       : system error, forces a stop
//   Motor_Esquerdo, Motor_Direito    : 00 stop, 01 forward, 10 reverse
//   Manobra_Ativa                    : high while stopping, reversing or turning
//   Manobra_Concluida                : one-cycle pulse after a completed turn
module controle_manobra_re
  import controle_manobra_re_pkg::*;
#(
  parameter int unsigned T_PARADA = 4,
  parameter int unsigned T_RE     = 16,
  parameter int unsigned T_GIRO   = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pedido_Re,
  input  logic       Sensor_Direito,
  input  logic       Sensor_Esquerdo,
  input  logic       Sensor_Trazeiro,
  input  logic       Saida_Erro,
  output logic [1:0] Motor_Esquerdo,
  output logic [1:0] Motor_Direito,
  output logic       Manobra_Ativa,
  output logic       Manobra_Concluida
);

  localparam logic [CNT_W-1:0] CARGA_PARADA = carga(T_PARADA);
  localparam logic [CNT_W-1:0] CARGA_RE     = carga(T_RE);
  localparam logic [CNT_W-1:0] CARGA_GIRO   = carga(T_GIRO);

  estado_t          estado_q, estado_d;
  logic             gira_esq_q, gira_esq_d;
  motores_t         motores_q, motores_d;
  logic             ativa_q, ativa_d;
  logic             concluida_q, concluida_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_valor;
  logic             cnt_zero;

  contador_manobra u_contador (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .valor (cnt_valor),
    .zero  (cnt_zero)
  );

  always_comb begin
    estado_d   = estado_q;
    gira_esq_d = gira_esq_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_valor  = '0;

    if (Saida_Erro) begin
      estado_d = ERRO;
    end else begin
      case (estado_q)
        ANDANDO: begin
          if (Pedido_Re) begin
            estado_d   = PARADA;
            // Obstacle only on the right side -> turn left; anything else -> right.
            gira_esq_d = Sensor_Direito & ~Sensor_Esquerdo;
            cnt_load   = 1'b1;
            cnt_valor  = CARGA_PARADA;
          end
        end
        PARADA: begin
          if (cnt_zero) begin
            estado_d  = RE;
            cnt_load  = 1'b1;
            cnt_valor = CARGA_RE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        RE: begin
          if (cnt_zero || Sensor_Trazeiro) begin
            estado_d  = GIRO;
            cnt_load  = 1'b1;
            cnt_valor = CARGA_GIRO;
          end else begin
            cnt_en = 1'b1;
          end
        end
        GIRO: begin
          if (cnt_zero) begin
            estado_d = ANDANDO;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ERRO:    estado_d = ANDANDO;
        default: estado_d = ANDANDO;
      endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    motores_d   = motores_do_estado(estado_d, gira_esq_d);
    ativa_d     = (estado_d == PARADA) || (estado_d == RE) || (estado_d == GIRO);
    concluida_d = (estado_q == GIRO) && (estado_d == ANDANDO);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado_q    <= ANDANDO;
      gira_esq_q  <= 1'b0;
      motores_q   <= '{esquerdo: PARADO, direito: PARADO};
      ativa_q     <= 1'b0;
      concluida_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      gira_esq_q  <= gira_esq_d;
      motores_q   <= motores_d;
      ativa_q     <= ativa_d;
      concluida_q <= concluida_d;
    end
  end

  assign Motor_Esquerdo    = motores_q.esquerdo;
  assign Motor_Direito     = motores_q.direito;
  assign Manobra_Ativa     = ativa_q;
  assign Manobra_Concluida = concluida_q;

endmodule

// File: tb/tb_controle_manobra_re.sv
// Bench for controle_manobra_re: two instances (default timing and all-ones timing)
// share the same stimulus. A timeline model predicts every output cycle; directed
// scenarios add literal expectations.
module tb_controle_manobra_re;

  localparam logic [1:0] P = 2'b00;
  localparam logic [1:0] F = 2'b01;
  localparam logic [1:0] T = 2'b10;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Pedido_Re = 1'b0;
  logic Sensor_Direito = 1'b0;
  logic Sensor_Esquerdo = 1'b0;
  logic Sensor_Trazeiro = 1'b0;
  logic Saida_Erro = 1'b0;

  logic [1:0] mot_e [2];
  logic [1:0] mot_d [2];
  logic       ativa [2];
  logic       conc  [2];

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  controle_manobra_re dut (
    .Clk (Clk), .Reset (Reset), .Pedido_Re (Pedido_Re),
    .Sensor_Direito (Sensor_Direito), .Sensor_Esquerdo (Sensor_Esquerdo),
    .Sensor_Trazeiro (Sensor_Trazeiro), .Saida_Erro (Saida_Erro),
    .Motor_Esquerdo (mot_e[0]), .Motor_Direito (mot_d[0]),
    .Manobra_Ativa (ativa[0]), .Manobra_Concluida (conc[0])
  );

  controle_manobra_re #(.T_PARADA(1), .T_RE(1), .T_GIRO(1)) dut1 (
    .Clk (Clk), .Reset (Reset), .Pedido_Re (Pedido_Re),
    .Sensor_Direito (Sensor_Direito), .Sensor_Esquerdo (Sensor_Esquerdo),
    .Sensor_Trazeiro (Sensor_Trazeiro), .Saida_Erro (Saida_Erro),
    .Motor_Esquerdo (mot_e[1]), .Motor_Direito (mot_d[1]),
    .Manobra_Ativa (ativa[1]), .Manobra_Concluida (conc[1])
  );

  function automatic logic [5:0] pk(logic [1:0] e, logic [1:0] d, logic a, logic c);
    return {e, d, a, c};
  endfunction

  function automatic logic [5:0] obs(int i);
    return {mot_e[i], mot_d[i], ativa[i], conc[i]};
  endfunction

  function automatic int t_par(int i);  return (i == 0) ? 4  : 1; endfunction
  function automatic int t_re(int i);   return (i == 0) ? 16 : 1; endfunction
  function automatic int t_giro(int i); return (i == 0) ? 8  : 1; endfunction

  // ---------------- timeline model ----------------
  // A manoeuvre is numbered by cycle: 1..TP stopped, then re_len reversing,
  // then TG turning, then one forward cycle with the completion pulse.
  bit         m_man     [2];
  int         m_n       [2];
  int         m_rel     [2];
  bit         m_esq     [2];
  bit         m_erro    [2];
  logic [5:0] m_exp     [2];
  bit         chk_en = 1'b0;

  function automatic logic [5:0] fase(int i, int nn);
    if (nn <= t_par(i)) return pk(P, P, 1'b1, 1'b0);
    if (nn <= t_par(i) + m_rel[i]) return pk(T, T, 1'b1, 1'b0);
    return m_esq[i] ? pk(T, F, 1'b1, 1'b0) : pk(F, T, 1'b1, 1'b0);
  endfunction

  initial forever begin
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_man[i] = 1'b0; m_erro[i] = 1'b0; m_exp[i] = pk(P, P, 1'b0, 1'b0);
      end else if (Saida_Erro) begin
        m_man[i] = 1'b0; m_erro[i] = 1'b1; m_exp[i] = pk(P, P, 1'b0, 1'b0);
      end else if (m_erro[i]) begin
        m_erro[i] = 1'b0; m_exp[i] = pk(F, F, 1'b0, 1'b0);
      end else if (!m_man[i]) begin
        if (Pedido_Re) begin
          m_man[i] = 1'b1; m_n[i] = 1; m_rel[i] = t_re(i);
          m_esq[i] = Sensor_Direito && !Sensor_Esquerdo;
          m_exp[i] = fase(i, 1);
        end else begin
          m_exp[i] = pk(F, F, 1'b0, 1'b0);
        end
      end else begin
        if (Sensor_Trazeiro && m_n[i] > t_par(i) && m_n[i] <= t_par(i) + m_rel[i])
          m_rel[i] = m_n[i] - t_par(i);
        m_n[i] = m_n[i] + 1;
        if (m_n[i] > t_par(i) + m_rel[i] + t_giro(i)) begin
          m_man[i] = 1'b0; m_exp[i] = pk(F, F, 1'b0, 1'b1);
        end else begin
          m_exp[i] = fase(i, m_n[i]);
        end
      end
    end
    if (Reset) chk_en = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (obs(i) !== m_exp[i]) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t got e/d/a/c=%b expected %b", i, $time, obs(i), m_exp[i]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(string nome, int i, logic [5:0] exp);
    tests++;
    if (obs(i) !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got e/d/a/c=%b expected %b", nome, i, obs(i), exp);
    end
    $display("[TB] %s dut%0d e/d/a/c=%b", nome, i, obs(i));
  endtask

  // Observes dut0 from manoeuvre cycle 1 to the cycle after the completion pulse.
  task automatic seq_check(string nome, int np, int nr, int ng, bit esq, int traz_at);
    logic [5:0] e;
    for (int j = 1; j <= np + nr + ng; j++) begin
      if (j <= np)           e = pk(P, P, 1'b1, 1'b0);
      else if (j <= np + nr) e = pk(T, T, 1'b1, 1'b0);
      else                   e = esq ? pk(T, F, 1'b1, 1'b0) : pk(F, T, 1'b1, 1'b0);
      chk($sformatf("%s_c%0d", nome, j), 0, e);
      Sensor_Trazeiro = (traz_at != 0) && (j == np + traz_at);
      step();
    end
    Sensor_Trazeiro = 1'b0;
    chk({nome, "_conc"}, 0, pk(F, F, 1'b0, 1'b1));
    step();
    chk({nome, "_fim"}, 0, pk(F, F, 1'b0, 1'b0));
  endtask

  task automatic pedido(bit dir, bit esq);
    Pedido_Re = 1'b1; Sensor_Direito = dir; Sensor_Esquerdo = esq;
    step();
    Pedido_Re = 1'b0; Sensor_Direito = 1'b0; Sensor_Esquerdo = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1;
    repeat (3) step();
    chk("reset", 0, pk(P, P, 1'b0, 1'b0));
    Reset = 1'b0;
    step();
    chk("pos_reset", 0, pk(F, F, 1'b0, 1'b0));

    // full default manoeuvre, right turn
    pedido(1'b0, 1'b0);
    seq_check("basico", 4, 16, 8, 1'b0, 0);

    // obstacle on the right only -> left turn
    pedido(1'b1, 1'b0);
    seq_check("giro_esq", 4, 16, 8, 1'b1, 0);

    // rear obstacle at reverse cycle 5
    pedido(1'b0, 1'b0);
    seq_check("traz5", 4, 5, 8, 1'b0, 5);

    // rear obstacle in the first reverse cycle
    pedido(1'b1, 1'b1);
    seq_check("traz1", 4, 1, 8, 1'b0, 1);

    // error during turn cycle 3, request held through the error
    pedido(1'b0, 1'b0);
    repeat (22) step();
    chk("giro3", 0, pk(F, T, 1'b1, 1'b0));
    Saida_Erro = 1'b1; Pedido_Re = 1'b1;
    step();
    chk("erro", 0, pk(P, P, 1'b0, 1'b0));
    step();
    chk("erro_hold", 0, pk(P, P, 1'b0, 1'b0));
    Saida_Erro = 1'b0;
    step();
    chk("erro_sai", 0, pk(F, F, 1'b0, 1'b0));
    step();
    chk("pedido_apos_erro", 0, pk(P, P, 1'b1, 1'b0));
    Pedido_Re = 1'b0;

    // request during reverse ignored; reset at reverse cycle 10
    repeat (5) step();
    Pedido_Re = 1'b1;
    step();
    Pedido_Re = 1'b0;
    repeat (7) step();
    chk("re10", 0, pk(T, T, 1'b1, 1'b0));
    Reset = 1'b1;
    step();
    chk("reset_re", 0, pk(P, P, 1'b0, 1'b0));
    Reset = 1'b0;
    step();
    chk("pos_reset_re", 0, pk(F, F, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("sem_fila", 0, pk(F, F, 1'b0, 1'b0));
    end

    // all-ones timing: three-cycle manoeuvre
    pedido(1'b0, 1'b0);
    chk("min_parada", 1, pk(P, P, 1'b1, 1'b0));
    step();
    chk("min_re", 1, pk(T, T, 1'b1, 1'b0));
    step();
    chk("min_giro", 1, pk(F, T, 1'b1, 1'b0));
    step();
    chk("min_conc", 1, pk(F, F, 1'b0, 1'b1));
    repeat (30) step();

    // randomized traffic checked by the model
    for (int k = 0; k < 4000; k++) begin
      Reset           = ($urandom_range(0, 299) == 0);
      Saida_Erro      = ($urandom_range(0, 59) == 0);
      Pedido_Re       = ($urandom_range(0, 7) == 0);
      Sensor_Trazeiro = ($urandom_range(0, 19) == 0);
      Sensor_Direito  = 1'($urandom_range(0, 1));
      Sensor_Esquerdo = 1'($urandom_range(0, 1));
      step();
    end
    Reset = 1'b0; Saida_Erro = 1'b0; Pedido_Re = 1'b0; Sensor_Trazeiro = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
